// File: rtl/tiny_prog_loader.sv
// tiny_prog_loader: fills the tiny_processor 16x8 instruction memory from a byte stream and
// gates the processor reset. Optional `CHECKSUM_EN adds a trailing checksum byte and ERROR state.
module tiny_prog_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              cpu_reset,
    output logic [ADDR_W-1:0] cpu_start_address,
    output logic              loaded,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
`ifdef CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;
`endif

    logic [2:0]                   state_q, state_d;
    logic [ADDR_W-1:0]            start_q, start_d;
    logic [ADDR_W-1:0]            last_q, last_d;
    logic [ADDR_W-1:0]            wptr_q, wptr_d;
    logic [ADDR_W:0]              words_q, words_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0]            sum_q, sum_d;
`endif
    logic                         xfer;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_HEADER, S_DATA: in_ready = 1'b1;
`ifdef CHECKSUM_EN
            S_CSUM:           in_ready = 1'b1;
`endif
            default:          in_ready = 1'b0;
        endcase
    end

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        last_d  = last_q;
        wptr_d  = wptr_q;
        words_d = words_q;
        mem_d   = mem_q;
`ifdef CHECKSUM_EN
        sum_d   = sum_q;
`endif
        // A new load request overrides everything, including a byte offered in the same cycle.
        if (load_start) begin
            state_d = S_HEADER;
        end else begin
            case (state_q)
                S_HEADER: if (xfer) begin
                    start_d = in_data[2*ADDR_W-1:ADDR_W];
                    last_d  = in_data[ADDR_W-1:0];
                    wptr_d  = '0;
                    words_d = '0;
`ifdef CHECKSUM_EN
                    sum_d   = in_data;
`endif
                    state_d = S_DATA;
                end
                S_DATA: if (xfer) begin
                    mem_d[wptr_q] = in_data;
                    words_d       = words_q + 1'b1;
`ifdef CHECKSUM_EN
                    sum_d         = sum_q + in_data;
`endif
                    if (wptr_q == last_q) begin
`ifdef CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_RUN;
`endif
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
`ifdef CHECKSUM_EN
                S_CSUM: if (xfer) begin
                    state_d = (DATA_W'(sum_q + in_data) == '0) ? S_RUN : S_ERROR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            start_q <= '0;
            last_q  <= '0;
            wptr_q  <= '0;
            words_q <= '0;
            mem_q   <= '0;
`ifdef CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            last_q  <= last_d;
            wptr_q  <= wptr_d;
            words_q <= words_d;
            mem_q   <= mem_d;
`ifdef CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign fetch_instr       = mem_q[fetch_addr];
    assign loaded            = (state_q == S_RUN);
    assign cpu_reset         = !loaded;
    assign cpu_start_address = start_q;
    assign words_loaded      = words_q;
`ifdef CHECKSUM_EN
    assign load_error        = (state_q == S_ERROR);
`else
    assign load_error        = 1'b0;
`endif
endmodule
